// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
// Optional checksum stage is enabled by LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_HDR,
    LDR_DATA,
    LDR_CSUM,
    LDR_DONE,
    LDR_ERR
  } loader_state_t;

  localparam int LDR_FIELD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the boot loader.
// The loader sits on the slave side; the host/memory side is master.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [31:0]       imem_wr_data;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic              imem_wr_en;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_wr_data,
    output imem_wr_addr,
    output imem_wr_en
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_wr_data,
    input  imem_wr_addr,
    input  imem_wr_en
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word.
// Used for the header, data and checksum fields alike.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST = 2'(LDR_FIELD_BYTES - 1);

  logic [1:0]  idx;
  logic [23:0] sr;

  // earliest byte ends up in the low lane
  assign word       = {rx_byte, sr};
  assign word_valid = byte_valid && (idx == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      idx <= '0;
      sr  <= '0;
    end else if (byte_valid) begin
      idx <= idx + 2'd1;
      sr  <= {rx_byte, sr[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header + words into imem, holds CPU in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit sum of the words.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_loader_if.slave      bus,
  input  logic              reload,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] word_cnt
);

  loader_state_t     state;
  logic [ADDR_W-1:0] n_last;
  logic [31:0]       wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              fire;
  logic              clear;
  logic [31:0]       word;
  logic              word_valid;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       csum;
`endif

  assign bus.rx_ready = rst_n &&
    (state == LDR_HDR || state == LDR_DATA ||
     state == LDR_CSUM);
  assign fire  = bus.rx_valid && bus.rx_ready;
  assign clear = (state == LDR_DONE) ||
                 (state == LDR_ERR);

  assign bus.imem_wr_data = wr_data;
  assign bus.imem_wr_addr = wr_addr;
  assign bus.imem_wr_en   = wr_en;

  imem_loader_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (fire),
    .rx_byte    (bus.rx_data),
    .clear      (clear),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LDR_HDR;
      n_last    <= '0;
      word_cnt  <= '0;
      wr_data   <= '0;
      wr_addr   <= '0;
      wr_en     <= 1'b0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        LDR_HDR: if (word_valid) begin
          if (word == 32'd0 ||
              word > 32'(MAX_WORDS)) begin
            state    <= LDR_ERR;
            load_err <= 1'b1;
          end else begin
            n_last <= ADDR_W'(word - 32'd1);
            state  <= LDR_DATA;
          end
        end
        LDR_DATA: if (word_valid) begin
          wr_data  <= word;
          wr_addr  <= word_cnt;
          wr_en    <= 1'b1;
          word_cnt <= word_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum     <= csum + word;
`endif
          if (word_cnt == n_last) begin
`ifdef LOADER_CHECKSUM_EN
            state     <= LDR_CSUM;
`else
            state     <= LDR_DONE;
            load_done <= 1'b1;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        LDR_CSUM: if (word_valid) begin
          if (word == csum) begin
            state     <= LDR_DONE;
            load_done <= 1'b1;
          end else begin
            state    <= LDR_ERR;
            load_err <= 1'b1;
          end
        end
`endif
        LDR_DONE, LDR_ERR: begin
          // one cycle of DONE lets the last write land first
          cpu_rst_n <= (state == LDR_DONE);
          if (reload) begin
            state     <= LDR_HDR;
            cpu_rst_n <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        default: state <= LDR_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus,
// popped by a negedge monitor. Checksum case needs LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reload = 1'b0;
  logic       cpu_rst_n;
  logic       load_done;
  logic       load_err;
  logic [9:0] word_cnt;

  int tests = 0;
  int fails = 0;

  logic [41:0] exp_q [$];

  imem_loader_if #(.ADDR_W(10)) bus ();

  imem_loader #(.MAX_WORDS(1024), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .reload    (reload),
    .cpu_rst_n (cpu_rst_n),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] t1 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                          8'h13, 8'h00, 8'h00, 8'h00,
                          8'h93, 8'h00, 8'h50, 8'h00};

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.imem_wr_en === 1'b1) begin
      logic [41:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %h data %h expected none",
                 bus.imem_wr_addr, bus.imem_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.imem_wr_addr, bus.imem_wr_data} !== e) begin
          fails++;
          $display("FAIL write: addr %h data %h expected addr %h data %h",
                   bus.imem_wr_addr, bus.imem_wr_data, e[41:32], e[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int idle);
    int t;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_t1(input int idle_max);
    exp_q.push_back({10'd0, 32'h0000_0013});
    exp_q.push_back({10'd1, 32'h0050_0093});
    for (int i = 0; i < 12; i++)
      send_byte(t1[i], $urandom_range(0, idle_max));
  endtask

  task automatic chk_done(input string tag);
`ifndef LOADER_CHECKSUM_EN
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_cpu_held"}, 32'(cpu_rst_n), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_cpu_rel"}, 32'(cpu_rst_n), 32'd1);
    chk({tag, "_cnt"}, 32'(word_cnt), 32'd2);
    chk({tag, "_rdy"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
`else
    chk({tag, "_wait_csum"}, 32'(load_done), 32'd0);
`endif
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++)
      send_byte(8'(w >> (8 * i)), 0);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(bus.rx_ready), 32'd0);
    chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_wr", 32'(bus.imem_wr_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_rdy", 32'(bus.rx_ready), 32'd1);

    // 1: basic two-word load
    send_t1(0);
    chk_done("t1");

    // 2: rejected headers
    do_reset();
    send_word(32'd0);
    chk("t2a_err", 32'(load_err), 32'd1);
    chk("t2a_rdy", 32'(bus.rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("t2a_cpu", 32'(cpu_rst_n), 32'd0);
    do_reset();
    send_word(32'd1025);
    chk("t2b_err", 32'(load_err), 32'd1);
    chk("t2b_rdy", 32'(bus.rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("t2b_cpu", 32'(cpu_rst_n), 32'd0);
    chk("t2b_done", 32'(load_done), 32'd0);

    // 3: idle gaps between bytes
    do_reset();
    send_t1(5);
    chk_done("t3");

    // 4: reset mid-word discards partial data
    do_reset();
    for (int i = 0; i < 6; i++)
      send_byte(t1[i], 0);
    do_reset();
    @(negedge clk);
    chk("t4_cnt", 32'(word_cnt), 32'd0);
    send_t1(0);
    chk_done("t4");

`ifndef LOADER_CHECKSUM_EN
    // 5: reload after DONE
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    chk("t5_cpu", 32'(cpu_rst_n), 32'd0);
    chk("t5_done", 32'(load_done), 32'd0);
    chk("t5_cnt", 32'(word_cnt), 32'd0);
    chk("t5_rdy", 32'(bus.rx_ready), 32'd1);
    exp_q.push_back({10'd0, 32'hDEAD_BEEF});
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    chk("t5_done2", 32'(load_done), 32'd1);
    @(posedge clk);
    #1;
    chk("t5_cpu2", 32'(cpu_rst_n), 32'd1);
    chk("t5_cnt2", 32'(word_cnt), 32'd1);
`else
    // 6: checksum match and mismatch
    send_word(32'h0050_00A6);
    chk("t6a_done", 32'(load_done), 32'd1);
    chk("t6a_cpu_held", 32'(cpu_rst_n), 32'd0);
    @(posedge clk);
    #1;
    chk("t6a_cpu", 32'(cpu_rst_n), 32'd1);
    do_reset();
    send_t1(0);
    send_word(32'h0050_00A7);
    chk("t6b_err", 32'(load_err), 32'd1);
    chk("t6b_done", 32'(load_done), 32'd0);
    repeat (2) @(negedge clk);
    chk("t6b_cpu", 32'(cpu_rst_n), 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
